// File: rtl/reg_writeback_pkg.sv
// Shared types for the integer register-file write-back slice.
// Optional feature macro used by this slice: WB_BYPASS_EN.
package reg_writeback_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  // Which execute unit owns the write port in a given cycle.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_t;

  localparam reg_addr_t WB_REG_ZERO = 5'd0;
  localparam word_t     WB_WORD_ZERO = 32'd0;

endpackage

// File: rtl/reg_writeback_scoreboard.sv
// reg_scoreboard: one pending bit per architectural register.
// A set marks a register as awaiting write-back; a clear retires it.
// Register 0 is hard-wired to never be pending.
module reg_scoreboard
  import reg_writeback_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  reg_addr_t        set_addr,
  input  logic             clr_en,
  input  reg_addr_t        clr_addr,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_r;

  // Pending bits: set has priority, though issue gating makes set/clear of one reg disjoint.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (set_en && (i != 0) && (set_addr == reg_addr_t'(i))) begin
          busy_r[i] <= 1'b1;
        end else if (clr_en && (clr_addr == reg_addr_t'(i))) begin
          busy_r[i] <= 1'b0;
        end else begin
          busy_r[i] <= busy_r[i];
        end
      end
    end
  end

  // Operand queries; x0 is always readable.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_addr != WB_REG_ZERO) begin
      rs1_busy = busy_r[rs1_addr];
    end else begin
      rs1_busy = 1'b0;
    end
    if (rs2_addr != WB_REG_ZERO) begin
      rs2_busy = busy_r[rs2_addr];
    end else begin
      rs2_busy = 1'b0;
    end
  end

  assign busy_vec = busy_r;

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU and LSU results onto a single registered
// register-file write port and tracks pending destinations for issue.
// Macro WB_BYPASS_EN adds forwarding of the in-flight write to rs1/rs2.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LSU_PRIORITY = 1,
  parameter int NREGS        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  reg_addr_t   issue_rd,
  output logic        issue_ready,
  input  reg_addr_t   rs1_addr,
  input  reg_addr_t   rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  reg_addr_t   alu_rd,
  input  word_t       alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  reg_addr_t   lsu_rd,
  input  word_t       lsu_data,
  output logic        write_en,
  output reg_addr_t   rd_addr,
  output word_t       rd_data
`ifdef WB_BYPASS_EN
  ,
  output logic        rs1_fwd,
  output logic        rs2_fwd,
  output word_t       rs1_fwd_data,
  output word_t       rs2_fwd_data
`endif
);

  localparam logic LSU_WINS = (LSU_PRIORITY != 0);

  logic             alu_ready_s;
  logic             lsu_ready_s;
  logic             accept_s;
  wb_src_t          src_s;
  reg_addr_t        acc_rd_s;
  word_t            acc_data_s;
  logic             issue_ready_s;
  logic             set_en_s;
  logic             sb_rs1_busy_s;
  logic             sb_rs2_busy_s;
  logic [NREGS-1:0] busy_vec_s;
  logic             write_en_r;
  reg_addr_t        rd_addr_r;
  word_t            rd_data_r;

  // Arbiter: the losing source sees ready=0 only when the other source is offering.
  always_comb begin
    alu_ready_s = 1'b0;
    lsu_ready_s = 1'b0;
    accept_s    = 1'b0;
    src_s       = WB_SRC_ALU;
    if (!rst_n) begin
      alu_ready_s = 1'b0;
      lsu_ready_s = 1'b0;
    end else begin
      if (LSU_WINS) begin
        alu_ready_s = !lsu_valid;
        lsu_ready_s = 1'b1;
      end else begin
        alu_ready_s = 1'b1;
        lsu_ready_s = !alu_valid;
      end
      if (lsu_valid && lsu_ready_s) begin
        accept_s = 1'b1;
        src_s    = WB_SRC_LSU;
      end else if (alu_valid && alu_ready_s) begin
        accept_s = 1'b1;
        src_s    = WB_SRC_ALU;
      end else begin
        accept_s = 1'b0;
        src_s    = WB_SRC_ALU;
      end
    end
  end

  // Payload mux for the winning source.
  always_comb begin
    acc_rd_s   = WB_REG_ZERO;
    acc_data_s = WB_WORD_ZERO;
    case (src_s)
      WB_SRC_LSU: begin
        acc_rd_s   = lsu_rd;
        acc_data_s = lsu_data;
      end
      WB_SRC_ALU: begin
        acc_rd_s   = alu_rd;
        acc_data_s = alu_data;
      end
      default: begin
        acc_rd_s   = WB_REG_ZERO;
        acc_data_s = WB_WORD_ZERO;
      end
    endcase
  end

  // Write port register; results for x0 are consumed without a strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_en_r <= 1'b0;
      rd_addr_r  <= WB_REG_ZERO;
      rd_data_r  <= WB_WORD_ZERO;
    end else if (accept_s && (acc_rd_s != WB_REG_ZERO)) begin
      write_en_r <= 1'b1;
      rd_addr_r  <= acc_rd_s;
      rd_data_r  <= acc_data_s;
    end else begin
      write_en_r <= 1'b0;
      rd_addr_r  <= rd_addr_r;
      rd_data_r  <= rd_data_r;
    end
  end

  // Issue is held off on WAW using the registered pending bit only, so a
  // set never lands on the register being cleared in the same cycle.
  always_comb begin
    issue_ready_s = 1'b0;
    set_en_s      = 1'b0;
    if (rst_n) begin
      issue_ready_s = !busy_vec_s[issue_rd];
      set_en_s      = issue_valid && issue_ready_s && (issue_rd != WB_REG_ZERO);
    end else begin
      issue_ready_s = 1'b0;
      set_en_s      = 1'b0;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en_s),
    .set_addr (issue_rd),
    .clr_en   (write_en_r),
    .clr_addr (rd_addr_r),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (sb_rs1_busy_s),
    .rs2_busy (sb_rs2_busy_s),
    .busy_vec (busy_vec_s)
  );

`ifdef WB_BYPASS_EN
  logic rs1_hit_s;
  logic rs2_hit_s;

  // Forward the in-flight write; the register file still returns the old value this cycle.
  always_comb begin
    rs1_hit_s = write_en_r && (rd_addr_r == rs1_addr) && (rs1_addr != WB_REG_ZERO);
    rs2_hit_s = write_en_r && (rd_addr_r == rs2_addr) && (rs2_addr != WB_REG_ZERO);
    if (rs1_hit_s) begin
      rs1_busy     = 1'b0;
      rs1_fwd      = 1'b1;
      rs1_fwd_data = rd_data_r;
    end else begin
      rs1_busy     = sb_rs1_busy_s;
      rs1_fwd      = 1'b0;
      rs1_fwd_data = WB_WORD_ZERO;
    end
    if (rs2_hit_s) begin
      rs2_busy     = 1'b0;
      rs2_fwd      = 1'b1;
      rs2_fwd_data = rd_data_r;
    end else begin
      rs2_busy     = sb_rs2_busy_s;
      rs2_fwd      = 1'b0;
      rs2_fwd_data = WB_WORD_ZERO;
    end
  end
`else
  assign rs1_busy = sb_rs1_busy_s;
  assign rs2_busy = sb_rs2_busy_s;
`endif

  assign issue_ready = issue_ready_s;
  assign alu_ready   = alu_ready_s;
  assign lsu_ready   = lsu_ready_s;
  assign write_en    = write_en_r;
  assign rd_addr     = rd_addr_r;
  assign rd_data     = rd_data_r;

endmodule
